grid_move_arbiter: RTL and testbench

- Owns both player positions and serialises all move and bomb-place requests from the keyboard path onto one shared tile-query port (wall/bomb lookup).
- Sits between the PS/2 decode path and the bomb/gadget/gameover blocks, in the clk_30 game domain.
- Round-robin arbitration between P1 and P2; at most one accepted request per player per game tick.
- Emits registered position, bomb-place pulses and reject pulses.

---
 rtl/grid_move_arbiter_pkg.sv | 26 ++
 rtl/grid_move_arbiter_req_slot.sv | 54 +++++
 rtl/grid_move_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_grid_move_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/grid_move_arbiter_pkg.sv
package grid_move_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  typedef logic [7:0] cor_t;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam cor_t P1_START_DEF = 8'h10;
  localparam cor_t P2_START_DEF = 8'h20;

  // Manhattan distance of exactly one, evaluated without wrap-around.
  function automatic logic is_adjacent(input cor_t a, input cor_t b);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = (a[3:0] >= b[3:0]) ? (a[3:0] - b[3:0]) : (b[3:0] - a[3:0]);
    dy = (a[7:4] >= b[7:4]) ? (a[7:4] - b[7:4]) : (b[7:4] - a[7:4]);
    return ({1'b0, dx} + {1'b0, dy}) == 5'd1;
  endfunction

endpackage

// File: rtl/grid_move_arbiter_req_slot.sv
module grid_move_arbiter_req_slot
  import grid_move_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic game_active,
  input  logic req_valid,
  input  logic req_bomb,
  input  cor_t req_cor,
  input  logic clr,
  output logic req_ready,
  output logic full,
  output logic bomb,
  output cor_t cor
);

  logic r_armed;
  logic r_full;
  logic r_bomb;
  cor_t r_cor;
  logic w_load;

  assign req_ready = game_active & r_armed & ~r_full;
  assign w_load    = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
      r_full  <= 1'b0;
      r_bomb  <= 1'b0;
      r_cor   <= '0;
    end else begin
      if (!game_active || clr) begin
        r_full <= 1'b0;
      end else if (w_load) begin
        r_full <= 1'b1;
        r_bomb <= req_bomb;
        r_cor  <= req_cor;
      end
      // A tick only re-arms once the pending request has been decided.
      if (w_load) begin
        r_armed <= 1'b0;
      end else if (tick && !r_full) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign full = r_full;
  assign bomb = r_bomb;
  assign cor  = r_cor;

endmodule

// File: rtl/grid_move_arbiter.sv
module grid_move_arbiter
  import grid_move_arbiter_pkg::*;
#(
  parameter int unsigned QUERY_LAT = 1,
  parameter cor_t        P1_START  = P1_START_DEF,
  parameter cor_t        P2_START  = P2_START_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       game_active,
  input  logic       p1_req_valid,
  input  logic       p1_req_bomb,
  input  logic [7:0] p1_req_cor,
  output logic       p1_req_ready,
  input  logic       p2_req_valid,
  input  logic       p2_req_bomb,
  input  logic [7:0] p2_req_cor,
  output logic       p2_req_ready,
  input  logic [2:0] p1_bomb_num,
  input  logic [2:0] p1_bomb_cap,
  input  logic [2:0] p2_bomb_num,
  input  logic [2:0] p2_bomb_cap,
  output logic       qry_valid,
  output logic [7:0] qry_cor,
  input  logic       qry_wall,
  input  logic       qry_bomb,
  output logic [7:0] p1_cor_o,
  output logic [7:0] p2_cor_o,
  output logic       p1_put_o,
  output logic       p2_put_o,
  output logic       p1_move_o,
  output logic       p2_move_o,
  output logic       p1_reject_o,
  output logic       p2_reject_o,
  output logic       busy
);

  state_t     r_state;
  logic       r_rr;
  logic       r_sel;
  logic       r_sel_bomb;
  logic       r_abort;
  logic       r_settle;
  logic [1:0] r_cnt;
  cor_t       r_qry_cor;
  logic       r_qry_valid;
  cor_t       r_p1_cor;
  cor_t       r_p2_cor;
  logic       r_p1_put, r_p2_put, r_p1_move, r_p2_move, r_p1_rej, r_p2_rej;

  logic [1:0] w_full;
  logic [1:0] w_bomb;
  logic [1:0] w_clr;
  cor_t       w_p1_slot_cor;
  cor_t       w_p2_slot_cor;
  logic       w_pick;
  logic       w_both;
  cor_t       w_cur;
  logic [2:0] w_num;
  logic [2:0] w_cap;
  logic       w_accept;

  grid_move_arbiter_req_slot u_slot_p1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .game_active (game_active),
    .req_valid   (p1_req_valid),
    .req_bomb    (p1_req_bomb),
    .req_cor     (p1_req_cor),
    .clr         (w_clr[P1]),
    .req_ready   (p1_req_ready),
    .full        (w_full[P1]),
    .bomb        (w_bomb[P1]),
    .cor         (w_p1_slot_cor)
  );

  grid_move_arbiter_req_slot u_slot_p2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .game_active (game_active),
    .req_valid   (p2_req_valid),
    .req_bomb    (p2_req_bomb),
    .req_cor     (p2_req_cor),
    .clr         (w_clr[P2]),
    .req_ready   (p2_req_ready),
    .full        (w_full[P2]),
    .bomb        (w_bomb[P2]),
    .cor         (w_p2_slot_cor)
  );

  always_comb begin
    w_both   = w_full[P1] & w_full[P2];
    w_pick   = w_both ? r_rr : (w_full[P1] ? P1 : P2);
    w_clr    = '0;
    w_clr[P1] = (r_state == DECIDE) && (r_sel == P1);
    w_clr[P2] = (r_state == DECIDE) && (r_sel == P2);
    w_cur    = (r_sel == P1) ? r_p1_cor    : r_p2_cor;
    w_num    = (r_sel == P1) ? p1_bomb_num : p2_bomb_num;
    w_cap    = (r_sel == P1) ? p1_bomb_cap : p2_bomb_cap;
    w_accept = 1'b0;
    if (game_active && !r_abort) begin
      if (r_sel_bomb) begin
        w_accept = (r_qry_cor == w_cur) && !qry_bomb && (w_num < w_cap);
      end else begin
        w_accept = !qry_wall && !qry_bomb && is_adjacent(w_cur, r_qry_cor);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr        <= P1;
      r_sel       <= P1;
      r_sel_bomb  <= 1'b0;
      r_abort     <= 1'b0;
      r_settle    <= 1'b0;
      r_cnt       <= '0;
      r_qry_cor   <= '0;
      r_qry_valid <= 1'b0;
      r_p1_cor    <= P1_START;
      r_p2_cor    <= P2_START;
      r_p1_put    <= 1'b0;
      r_p2_put    <= 1'b0;
      r_p1_move   <= 1'b0;
      r_p2_move   <= 1'b0;
      r_p1_rej    <= 1'b0;
      r_p2_rej    <= 1'b0;
    end else begin
      r_qry_valid <= 1'b0;
      r_settle    <= 1'b0;
      r_p1_put    <= 1'b0;
      r_p2_put    <= 1'b0;
      r_p1_move   <= 1'b0;
      r_p2_move   <= 1'b0;
      r_p1_rej    <= 1'b0;
      r_p2_rej    <= 1'b0;
      case (r_state)
        IDLE: begin
          // One idle cycle after each decision so a queued loser lands a
          // full decision period behind the winner.
          if (game_active && !r_settle && (w_full != 2'b00)) begin
            r_sel       <= w_pick;
            r_sel_bomb  <= w_bomb[w_pick];
            r_qry_cor   <= (w_pick == P1) ? w_p1_slot_cor : w_p2_slot_cor;
            r_qry_valid <= 1'b1;
            r_cnt       <= 2'(QUERY_LAT);
            r_abort     <= 1'b0;
            r_state     <= WAIT;
            if (w_both) r_rr <= ~r_rr;
          end
        end
        WAIT: begin
          if (!game_active) r_abort <= 1'b1;
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) r_state <= DECIDE;
        end
        DECIDE: begin
          r_state  <= IDLE;
          r_settle <= 1'b1;
          if (r_sel == P1) begin
            if (!w_accept)       r_p1_rej  <= 1'b1;
            else if (r_sel_bomb) r_p1_put  <= 1'b1;
            else begin
              r_p1_move <= 1'b1;
              r_p1_cor  <= r_qry_cor;
            end
          end else begin
            if (!w_accept)       r_p2_rej  <= 1'b1;
            else if (r_sel_bomb) r_p2_put  <= 1'b1;
            else begin
              r_p2_move <= 1'b1;
              r_p2_cor  <= r_qry_cor;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign qry_valid   = r_qry_valid;
  assign qry_cor     = r_qry_cor;
  assign p1_cor_o    = r_p1_cor;
  assign p2_cor_o    = r_p2_cor;
  assign p1_put_o    = r_p1_put;
  assign p2_put_o    = r_p2_put;
  assign p1_move_o   = r_p1_move;
  assign p2_move_o   = r_p2_move;
  assign p1_reject_o = r_p1_rej;
  assign p2_reject_o = r_p2_rej;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_grid_move_arbiter.sv
module tb_grid_move_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, game_active;
  logic       p1_req_valid, p1_req_bomb, p1_req_ready;
  logic [7:0] p1_req_cor;
  logic       p2_req_valid, p2_req_bomb, p2_req_ready;
  logic [7:0] p2_req_cor;
  logic [2:0] p1_bomb_num, p1_bomb_cap, p2_bomb_num, p2_bomb_cap;
  logic       qry_valid, qry_wall, qry_bomb;
  logic [7:0] qry_cor;
  logic [7:0] p1_cor_o, p2_cor_o;
  logic       p1_put_o, p2_put_o, p1_move_o, p2_move_o, p1_reject_o, p2_reject_o;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  grid_move_arbiter #(
    .QUERY_LAT (1),
    .P1_START  (8'h10),
    .P2_START  (8'h20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .game_active  (game_active),
    .p1_req_valid (p1_req_valid),
    .p1_req_bomb  (p1_req_bomb),
    .p1_req_cor   (p1_req_cor),
    .p1_req_ready (p1_req_ready),
    .p2_req_valid (p2_req_valid),
    .p2_req_bomb  (p2_req_bomb),
    .p2_req_cor   (p2_req_cor),
    .p2_req_ready (p2_req_ready),
    .p1_bomb_num  (p1_bomb_num),
    .p1_bomb_cap  (p1_bomb_cap),
    .p2_bomb_num  (p2_bomb_num),
    .p2_bomb_cap  (p2_bomb_cap),
    .qry_valid    (qry_valid),
    .qry_cor      (qry_cor),
    .qry_wall     (qry_wall),
    .qry_bomb     (qry_bomb),
    .p1_cor_o     (p1_cor_o),
    .p2_cor_o     (p2_cor_o),
    .p1_put_o     (p1_put_o),
    .p2_put_o     (p2_put_o),
    .p1_move_o    (p1_move_o),
    .p2_move_o    (p2_move_o),
    .p1_reject_o  (p1_reject_o),
    .p2_reject_o  (p2_reject_o),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rearm();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic issue(input bit p2, input bit bomb, input logic [7:0] cor);
    if (p2) begin
      p2_req_valid = 1'b1; p2_req_bomb = bomb; p2_req_cor = cor;
    end else begin
      p1_req_valid = 1'b1; p1_req_bomb = bomb; p1_req_cor = cor;
    end
    step(1);
    p1_req_valid = 1'b0;
    p2_req_valid = 1'b0;
  endtask

  task automatic issue_both(input logic [7:0] c1, input logic [7:0] c2);
    p1_req_valid = 1'b1; p1_req_bomb = 1'b0; p1_req_cor = c1;
    p2_req_valid = 1'b1; p2_req_bomb = 1'b0; p2_req_cor = c2;
    step(1);
    p1_req_valid = 1'b0;
    p2_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; game_active = 1'b1;
    p1_req_valid = 1'b0; p1_req_bomb = 1'b0; p1_req_cor = '0;
    p2_req_valid = 1'b0; p2_req_bomb = 1'b0; p2_req_cor = '0;
    p1_bomb_num = '0; p1_bomb_cap = '0; p2_bomb_num = '0; p2_bomb_cap = '0;
    qry_wall = 1'b0; qry_bomb = 1'b0;
    step(3);
    check("rst_p1_cor", p1_cor_o, 8'h10);
    check("rst_p2_cor", p2_cor_o, 8'h20);
    check("rst_p1_rdy", p1_req_ready, 1);
    check("rst_p2_rdy", p2_req_ready, 1);
    check("rst_pulses", {p1_put_o, p2_put_o, p1_move_o, p2_move_o, p1_reject_o, p2_reject_o}, 0);
    check("rst_busy", busy, 0);
    check("rst_qry", {qry_valid, qry_cor}, 0);
    rst_n = 1'b1;
    step(1);

    // Wrap 10 -> 1F is not adjacent.
    issue(0, 0, 8'h1F);
    step(3);
    check("wrap_rej", p1_reject_o, 1);
    check("wrap_cor", p1_cor_o, 8'h10);
    rearm();

    // Wall blocks a legal step.
    qry_wall = 1'b1;
    issue(0, 0, 8'h11);
    step(3);
    check("wall_rej", p1_reject_o, 1);
    check("wall_mv", p1_move_o, 0);
    qry_wall = 1'b0;
    rearm();

    // Legal move 10 -> 11, cycle by cycle.
    check("mv_rdy_pre", p1_req_ready, 1);
    issue(0, 0, 8'h11);
    check("mv_rdy_n1", p1_req_ready, 0);
    check("mv_busy_n1", busy, 0);
    step(1);
    check("mv_qv_n2", qry_valid, 1);
    check("mv_qc_n2", qry_cor, 8'h11);
    check("mv_busy_n2", busy, 1);
    step(1);
    check("mv_qv_n3", qry_valid, 0);
    check("mv_pulse_n3", p1_move_o, 0);
    step(1);
    check("mv_pulse_n4", p1_move_o, 1);
    check("mv_cor_n4", p1_cor_o, 8'h11);
    check("mv_rej_n4", p1_reject_o, 0);
    step(1);
    check("mv_pulse_n5", p1_move_o, 0);
    check("mv_rdy_n5", p1_req_ready, 0);
    rearm();
    check("mv_rdy_tick", p1_req_ready, 1);

    // P2 bomb at own tile, capacity full then with room.
    p2_bomb_num = 3'd2; p2_bomb_cap = 3'd2;
    issue(1, 1, 8'h20);
    step(3);
    check("bomb_full_rej", p2_reject_o, 1);
    check("bomb_full_put", p2_put_o, 0);
    rearm();
    p2_bomb_num = 3'd1;
    issue(1, 1, 8'h20);
    step(1);
    check("bomb_qc", qry_cor, 8'h20);
    step(2);
    check("bomb_put", p2_put_o, 1);
    check("bomb_rej", p2_reject_o, 0);
    check("bomb_cor", p2_cor_o, 8'h20);
    step(1);
    check("bomb_put_end", p2_put_o, 0);
    rearm();

    // Contention: P1 wins first, then P2 wins the next pair.
    issue_both(8'h12, 8'h21);
    step(3);
    check("c1_p1_mv", p1_move_o, 1);
    check("c1_p2_mv_early", p2_move_o, 0);
    check("c1_p1_cor", p1_cor_o, 8'h12);
    step(3);
    check("c1_p2_mv_n7", p2_move_o, 0);
    check("c1_busy_n7", busy, 1);
    step(1);
    check("c1_p2_mv_n8", p2_move_o, 1);
    check("c1_p2_cor", p2_cor_o, 8'h21);
    rearm();
    issue_both(8'h13, 8'h22);
    step(3);
    check("c2_p2_mv", p2_move_o, 1);
    check("c2_p1_mv_early", p1_move_o, 0);
    check("c2_p2_cor", p2_cor_o, 8'h22);
    step(4);
    check("c2_p1_mv_n8", p1_move_o, 1);
    check("c2_p1_cor", p1_cor_o, 8'h13);
    rearm();

    // game_active drops while P1 waits on the query; P2's pending slot flushes.
    issue_both(8'h14, 8'h23);
    step(1);
    check("ga_qc", qry_cor, 8'h14);
    game_active = 1'b0;
    step(2);
    check("ga_p1_rej", p1_reject_o, 1);
    check("ga_p1_mv", p1_move_o, 0);
    check("ga_p1_cor", p1_cor_o, 8'h13);
    check("ga_rdy", {p1_req_ready, p2_req_ready}, 2'b00);
    rearm();
    step(3);
    check("ga_p2_pulses", {p2_move_o, p2_reject_o, p2_put_o}, 0);
    check("ga_p2_cor", p2_cor_o, 8'h22);
    check("ga_busy", busy, 0);
    check("ga_rdy_hold", {p1_req_ready, p2_req_ready}, 2'b00);
    game_active = 1'b1;
    step(1);
    check("ga_rdy_back", {p1_req_ready, p2_req_ready}, 2'b11);

    // Reset asserted in DECIDE.
    issue(0, 0, 8'h14);
    step(2);
    check("rd_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rd_p1_cor", p1_cor_o, 8'h10);
    check("rd_p2_cor", p2_cor_o, 8'h20);
    check("rd_busy0", busy, 0);
    step(1);
    check("rd_no_pulse", {p1_move_o, p1_reject_o, p1_put_o}, 0);
    check("rd_cor_hold", p1_cor_o, 8'h10);
    rst_n = 1'b1;
    step(1);
    check("rd_rdy", p1_req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
